i2c_slave_core: RTL and testbench

//   I2C-style single-byte slave, clocked directly by the bus clock SCL.

---
 rtl/i2c_slave_core_if.sv | 19 +
 rtl/i2c_slave_core.sv | 157 +++++++++++++++
 tb/tb_i2c_slave_core.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_core_if.sv
// ============================================================================
// Module  : i2c_slave_core_if
// Brief   : Register-side signals of the single-byte I2C slave core.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface i2c_slave_core_if;
    logic [6:0] addr;
    logic [7:0] data_rd;
    logic [7:0] data_wr;
    logic       done;

    modport slave  (input addr, input data_rd, output data_wr, output done);
    modport master (output addr, output data_rd, input data_wr, input done);
endinterface

`default_nettype wire

// File: rtl/i2c_slave_core.sv
// ============================================================================
// Module  : i2c_slave_core
// Brief   : Single-byte I2C-style slave clocked by SCL, one bit per period.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_slave_core (
    input  wire logic        SCL,
    input  wire logic        rst,
    i2c_slave_core_if.slave  bus,
    inout  wire              SDA
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] ADDR      = 4'd1;
    localparam logic [3:0] SKIP      = 4'd2;
    localparam logic [3:0] WACK1     = 4'd3;
    localparam logic [3:0] WDATA     = 4'd4;
    localparam logic [3:0] WACK2     = 4'd5;
    localparam logic [3:0] RDATA     = 4'd6;
    localparam logic [3:0] RACK      = 4'd7;
    localparam logic [3:0] STOP_WAIT = 4'd8;

    logic [3:0] state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [7:0] sh_q,    sh_d;
    logic [7:0] wr_q,    wr_d;
    logic       done_q,  done_d;
    logic       oe_q,    oe_d;
    logic       out_q,   out_d;
    logic       low_q,   low_d;
    logic       sda_in;

    assign sda_in      = SDA;
    assign SDA         = oe_q ? out_q : 1'bz;
    assign bus.data_wr = wr_q;
    assign bus.done    = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        wr_d    = wr_q;
        done_d  = 1'b0;
        oe_d    = oe_q;
        out_d   = out_q;
        low_d   = low_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (!sda_in) state_d = ADDR;
            end
            ADDR: begin
                if (cnt_q == 4'd7) begin
                    // The eighth bit is R/W; sh_q[6:0] now holds the full address.
                    cnt_d = 4'd0;
                    if (sh_q[6:0] != bus.addr) begin
                        state_d = SKIP;
                    end else if (sda_in) begin
                        state_d = RDATA;
                        oe_d    = 1'b1;
                        out_d   = bus.data_rd[7];
                        sh_d    = {bus.data_rd[6:0], 1'b0};
                    end else begin
                        state_d = WACK1;
                        oe_d    = 1'b1;
                        out_d   = 1'b0;
                    end
                end else begin
                    sh_d  = {sh_q[6:0], sda_in};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SKIP: begin
                if (cnt_q == 4'd8) begin
                    state_d = STOP_WAIT;
                    low_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WACK1: begin
                oe_d    = 1'b0;
                cnt_d   = 4'd0;
                state_d = WDATA;
            end
            WDATA: begin
                sh_d = {sh_q[6:0], sda_in};
                if (cnt_q == 4'd7) begin
                    wr_d    = {sh_q[6:0], sda_in};
                    done_d  = 1'b1;
                    oe_d    = 1'b1;
                    out_d   = 1'b0;
                    state_d = WACK2;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WACK2: begin
                oe_d    = 1'b0;
                low_d   = 1'b0;
                state_d = STOP_WAIT;
            end
            RDATA: begin
                if (cnt_q == 4'd7) begin
                    oe_d    = 1'b0;
                    state_d = RACK;
                end else begin
                    out_d = sh_q[7];
                    sh_d  = {sh_q[6:0], 1'b0};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RACK: begin
                // Master ACK/NACK is sampled here but has no effect.
                done_d  = 1'b1;
                low_d   = 1'b0;
                state_d = STOP_WAIT;
            end
            STOP_WAIT: begin
                if (low_q && sda_in) state_d = IDLE;
                low_d = !sda_in;
            end
            default: begin
                state_d = IDLE;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SCL) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 8'h00;
            wr_q    <= 8'h00;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
            low_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            low_q   <= low_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_core.sv
// ============================================================================
// Module  : tb_i2c_slave_core
// Brief   : Directed-frame bench for i2c_slave_core with a queued scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_slave_core;

    localparam logic [6:0] OWN     = 7'h0F;
    localparam int         K_SDA   = 0;
    localparam int         K_DATA  = 1;
    localparam int         K_DONE0 = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic SCL   = 1'b0;
    logic rst   = 1'b1;
    logic m_oe  = 1'b1;
    logic m_val = 1'b1;
    wire  SDA;

    // Open-drain style bus: undriven SDA reads as 1.
    assign SDA = m_oe ? m_val : 1'bz;
    pullup (SDA);

    i2c_slave_core_if bus ();

    i2c_slave_core dut (
        .SCL (SCL),
        .rst (rst),
        .bus (bus),
        .SDA (SDA)
    );

    always #5 SCL = ~SCL;

    int cyc = 0;
    always @(posedge SCL) cyc <= cyc + 1;

    exp_t       chk_q[$];
    exp_t       done_q[$];
    int         n_chk    = 0;
    int         n_err    = 0;
    logic [7:0] model_wr = 8'h00;
    logic [7:0] rd_val   = 8'hAB;
    logic       fin      = 1'b0;
    logic       mon_done = 1'b0;

    task automatic push_chk(input int c, input int k, input logic [7:0] v);
        exp_t e;
        e.cyc = c; e.kind = k; e.val = v;
        chk_q.push_back(e);
    endtask

    task automatic push_done(input int c, input logic [7:0] v);
        exp_t e;
        e.cyc = c; e.kind = 0; e.val = v;
        done_q.push_back(e);
    endtask

    // One master frame; act codes: 0/1 drive level, 2 release.
    task automatic frame(input logic [6:0] a, input logic rw, input logic [7:0] d,
                         input logic abort);
        int   s;
        int   last;
        int   act[0:19];
        logic match;
        @(posedge SCL); #1;
        m_oe = 1'b1; m_val = 1'b0;
        s     = cyc + 1;
        match = (a == OWN);
        for (int k = 0; k < 20; k++) act[k] = 1;
        for (int k = 0; k < 7; k++) act[k] = int'(a[6-k]);
        act[7] = int'(rw);
        if (!rw) begin
            act[8] = 2;
            for (int k = 9; k < 17; k++) act[k] = int'(d[16-k]);
            act[17] = 2; act[18] = 0; act[19] = 1; last = 19;
            push_chk(s + 8, K_SDA, match ? 8'h00 : 8'h01);
            if (abort) begin
                push_chk(s + 17, K_SDA, 8'h01);
                push_chk(s + 17, K_DONE0, 8'h00);
                push_chk(s + 17, K_DATA, 8'h00);
                model_wr = 8'h00;
            end else if (match) begin
                push_chk(s + 17, K_SDA, 8'h00);
                push_done(s + 17, d);
                model_wr = d;
            end else begin
                push_chk(s + 17, K_SDA, 8'h01);
                push_chk(s + 17, K_DATA, model_wr);
                push_chk(s + 17, K_DONE0, 8'h00);
            end
        end else begin
            for (int k = 8; k < 16; k++) act[k] = 2;
            act[16] = 1; act[17] = 0; act[18] = 1; last = 18;
            for (int i = 0; i < 8; i++) push_chk(s + 8 + i, K_SDA, {7'b0, rd_val[7-i]});
            push_done(s + 17, model_wr);
        end
        for (int k = 0; k <= last; k++) begin
            @(posedge SCL); #1;
            if (abort && k == 17) begin
                rst = 1'b0; m_oe = 1'b1; m_val = 1'b1;
                break;
            end
            if (abort && k == 16) rst = 1'b1;
            if (act[k] == 2) begin
                m_oe = 1'b0;
            end else begin
                m_oe = 1'b1; m_val = act[k][0];
            end
        end
        m_oe = 1'b1; m_val = 1'b1;
    endtask

    always @(negedge SCL) begin : monitor
        exp_t e;
        if (bus.done === 1'b1) begin
            n_chk++;
            if (done_q.size() == 0) begin
                n_err++;
                $display("FAIL done_unexpected: cyc=%0d done=1, required done=0", cyc);
            end else begin
                e = done_q.pop_front();
                if (e.cyc != cyc || bus.data_wr !== e.val) begin
                    n_err++;
                    $display("FAIL done_pulse: cyc=%0d data_wr=%h, required cyc=%0d data_wr=%h",
                             cyc, bus.data_wr, e.cyc, e.val);
                end
            end
        end
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            e = chk_q.pop_front();
            n_chk++;
            case (e.kind)
                K_SDA: if (e.cyc != cyc || SDA !== e.val[0]) begin
                    n_err++;
                    $display("FAIL sda: cyc=%0d SDA=%b, required cyc=%0d SDA=%b",
                             cyc, SDA, e.cyc, e.val[0]);
                end
                K_DATA: if (e.cyc != cyc || bus.data_wr !== e.val) begin
                    n_err++;
                    $display("FAIL data_wr: cyc=%0d data_wr=%h, required cyc=%0d data_wr=%h",
                             cyc, bus.data_wr, e.cyc, e.val);
                end
                default: if (e.cyc != cyc || bus.done !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_low: cyc=%0d done=%b, required cyc=%0d done=0",
                             cyc, bus.done, e.cyc);
                end
            endcase
        end
        if (fin && !mon_done) begin
            n_chk++;
            if (chk_q.size() + done_q.size() != 0) begin
                n_err++;
                $display("FAIL pending: %0d checks and %0d done pulses outstanding, required 0",
                         chk_q.size(), done_q.size());
            end
            mon_done = 1'b1;
        end
    end

    initial begin
        bus.addr    = OWN;
        bus.data_rd = rd_val;
        repeat (2) @(posedge SCL);
        #1 rst = 1'b0;
        push_chk(cyc, K_SDA, 8'h01);
        push_chk(cyc, K_DATA, 8'h00);
        push_chk(cyc, K_DONE0, 8'h00);
        repeat (2) @(posedge SCL);

        frame(OWN, 1'b0, 8'hAB, 1'b0);
        frame(OWN, 1'b0, 8'hAB, 1'b0);
        frame(OWN, 1'b1, 8'h00, 1'b0);
        frame(OWN, 1'b1, 8'h00, 1'b0);
        frame(7'h10, 1'b0, 8'h55, 1'b0);
        frame(OWN, 1'b0, 8'hC3, 1'b1);
        frame(OWN, 1'b0, 8'h3C, 1'b0);
        #1 rd_val = 8'h5A;
        bus.data_rd = rd_val;
        frame(OWN, 1'b1, 8'h00, 1'b0);

        repeat (5) @(posedge SCL);
        fin = 1'b1;
        repeat (3) @(posedge SCL);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
